// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, redirect handling and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall_cycles counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  Op_code,
  output logic [5:0]  Funct,
  output logic [4:0]  Shamt,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        req_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Branch outranks jump; the jump region comes from the instruction currently in IF/ID.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target
                                 : {ifid_pc4_q[31:28], jump_index, 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    pending_d    = pending_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            // The outstanding request cannot be withdrawn, so its data gets dropped later.
            pending_d = target;
            state_d   = S_DROP;
          end
        end else if (imem_ready) begin
          if (stall || flush) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
            if (flush) begin
              ifid_instr_d = 32'h0;
              ifid_valid_d = 1'b0;
            end
          end else begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end
        end else if (flush || !stall) begin
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d         = target;
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (flush) begin
          ifid_instr_d = 32'h0;
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d = hold_q;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          state_d      = S_REQ;
        end
      end

      S_DROP: begin
        ifid_instr_d = 32'h0;
        ifid_valid_d = 1'b0;
        if (imem_ready) begin
          pc_d    = redirect ? target : pending_q;
          state_d = S_REQ;
        end else if (redirect) begin
          pending_d = target;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      hold_q       <= 32'h0;
      pending_q    <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      req_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      req_q        <= (state_d != S_HOLD);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;
  logic        load_valid;

  // Only a real IF/ID load advances the PC while producing valid=1; holds and redirects do not.
  assign load_valid = ifid_valid_d && (pc_d != pc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      if (load_valid) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall && state_q != S_DROP) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

  assign imem_req       = req_q;
  assign imem_addr      = pc_q;
  assign if_id_instr    = ifid_instr_q;
  assign if_id_pc_plus4 = ifid_pc4_q;
  assign if_id_valid    = ifid_valid_q;
  assign Op_code        = ifid_instr_q[31:26];
  assign Funct          = ifid_instr_q[5:0];
  assign Shamt          = ifid_instr_q[10:6];
  assign Rs             = ifid_instr_q[25:21];
  assign Rt             = ifid_instr_q[20:16];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each record drives one cycle of inputs
// and lists the hand-computed outputs expected just after the following rising edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        jump;
  logic [25:0] jumpIndex;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPcPlus4;
  logic        ifIdValid;
  logic [5:0]  opCode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rs;
  logic [4:0]  rt;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .jump           (jump),
    .jump_index     (jumpIndex),
    .branch_taken   (branchTaken),
    .branch_target  (branchTarget),
    .imem_req       (imemReq),
    .imem_addr      (imemAddr),
    .imem_ready     (imemReady),
    .imem_rdata     (imemRdata),
    .if_id_instr    (ifIdInstr),
    .if_id_pc_plus4 (ifIdPcPlus4),
    .if_id_valid    (ifIdValid),
    .Op_code        (opCode),
    .Funct          (funct),
    .Shamt          (shamt),
    .Rs             (rs),
    .Rt             (rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        jump;
    logic [25:0] jidx;
    logic        br;
    logic [31:0] btgt;
    logic        ready;
    logic [31:0] rdata;
    logic        eReq;
    logic [31:0] eAddr;
    logic [31:0] eInstr;
    logic [31:0] ePc4;
    logic        eValid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic f, logic j, logic [25:0] ji, logic b,
                              logic [31:0] bt, logic r, logic [31:0] rd, logic er,
                              logic [31:0] ea, logic [31:0] ei, logic [31:0] ep, logic ev);
    vec_t v;
    v.stall = s;  v.flush = f;  v.jump = j;  v.jidx = ji;  v.br = b;  v.btgt = bt;
    v.ready = r;  v.rdata = rd; v.eReq = er; v.eAddr = ea; v.eInstr = ei;
    v.ePc4 = ep;  v.eValid = ev;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one record's inputs, clock once, and compare every output a cycle later.
  task automatic applyStimulus(input vec_t v, input string tag);
    stall        = v.stall;
    flush        = v.flush;
    jump         = v.jump;
    jumpIndex    = v.jidx;
    branchTaken  = v.br;
    branchTarget = v.btgt;
    imemReady    = v.ready;
    imemRdata    = v.rdata;
    @(posedge clk);
    #1;
    checkOutput({tag, ".req"},   {31'h0, imemReq},   {31'h0, v.eReq});
    checkOutput({tag, ".addr"},  imemAddr,           v.eAddr);
    checkOutput({tag, ".instr"}, ifIdInstr,          v.eInstr);
    checkOutput({tag, ".pc4"},   ifIdPcPlus4,        v.ePc4);
    checkOutput({tag, ".valid"}, {31'h0, ifIdValid}, {31'h0, v.eValid});
    checkOutput({tag, ".fields"},
                {6'h0, opCode, rs, rt, shamt, funct},
                {6'h0, v.eInstr[31:26], v.eInstr[25:21], v.eInstr[20:16],
                 v.eInstr[10:6], v.eInstr[5:0]});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset must win over a simultaneous jump and ready beat.
    rst = 1'b1;
    applyStimulus(mk(0,0,1,26'h3FF,1,32'h8000_0000,1,32'hFFFF_FFFF, 1,32'h0,32'h0,32'h0,0), "reset");
    rst = 1'b0;

    //             st fl jp jidx     br btgt          rdy rdata          req addr           instr          pc4            v
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h2008_0005,   1,32'h4,         32'h2008_0005, 32'h4,         1));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'hAAAA_0001,   1,32'h8,         32'hAAAA_0001, 32'h8,         1));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h8,         32'h0,         32'h8,         0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h8,         32'h0,         32'h8,         0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h8,         32'h0,         32'h8,         0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h1111_2222,   1,32'hC,         32'h1111_2222, 32'hC,         1));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h3333_4444,   1,32'h10,        32'h3333_4444, 32'h10,        1));
    vecs.push_back(mk(1,0,0,26'h0,   0,32'h0,         1,32'h5555_6666,   0,32'h10,        32'h3333_4444, 32'h10,        1));
    vecs.push_back(mk(1,0,0,26'h0,   0,32'h0,         0,32'h0,           0,32'h10,        32'h3333_4444, 32'h10,        1));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h14,        32'h5555_6666, 32'h14,        1));
    vecs.push_back(mk(0,0,0,26'h0,   1,32'h100,       0,32'h0,           1,32'h14,        32'h0,         32'h14,        0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h14,        32'h0,         32'h14,        0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'hDEAD_BEEF,   1,32'h100,       32'h0,         32'h14,        0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h0000_0BAD,   1,32'h104,       32'h0000_0BAD, 32'h104,       1));
    vecs.push_back(mk(0,0,0,26'h0,   1,32'h1000_0004, 1,32'h0BAD_0BAD,   1,32'h1000_0004, 32'h0,         32'h104,       0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h0800_0040,   1,32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1));
    vecs.push_back(mk(0,0,1,26'h40,  1,32'h200,       1,32'h0,           1,32'h200,       32'h0,         32'h1000_0008, 0));
    vecs.push_back(mk(0,0,1,26'h40,  0,32'h0,         1,32'h0,           1,32'h1000_0100, 32'h0,         32'h1000_0008, 0));
    vecs.push_back(mk(0,1,0,26'h0,   0,32'h0,         1,32'h7777_0000,   0,32'h1000_0100, 32'h0,         32'h1000_0008, 0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h1000_0104, 32'h7777_0000, 32'h1000_0104, 1));
    vecs.push_back(mk(1,1,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h1000_0104, 32'h0,         32'h1000_0104, 0));
    vecs.push_back(mk(1,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h1000_0104, 32'h0,         32'h1000_0104, 0));
    vecs.push_back(mk(0,0,0,26'h0,   1,32'hFFFF_FFFC, 1,32'h0,           1,32'hFFFF_FFFC, 32'h0,         32'h1000_0104, 0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h0123_4567,   1,32'h0,         32'h0123_4567, 32'h0,         1));
    vecs.push_back(mk(0,0,1,26'h3,   0,32'h0,         0,32'h0,           1,32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(0,0,0,26'h0,   1,32'h40,        0,32'h0,           1,32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'hBAD0_BAD0,   1,32'h40,        32'h0,         32'h0,         0));
    vecs.push_back(mk(0,0,0,26'h0,   1,32'h80,        0,32'h0,           1,32'h40,        32'h0,         32'h0,         0));
    vecs.push_back(mk(0,0,0,26'h0,   1,32'h90,        1,32'hBAD1_BAD1,   1,32'h90,        32'h0,         32'h0,         0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'hCAFE_0001,   1,32'h94,        32'hCAFE_0001, 32'h94,        1));
    vecs.push_back(mk(1,0,0,26'h0,   0,32'h0,         1,32'h0000_0001,   0,32'h94,        32'hCAFE_0001, 32'h94,        1));
    vecs.push_back(mk(1,0,0,26'h0,   1,32'h200,       0,32'h0,           1,32'h200,       32'h0,         32'h94,        0));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         1,32'h4444_0000,   1,32'h204,       32'h4444_0000, 32'h204,       1));
    vecs.push_back(mk(1,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h204,       32'h4444_0000, 32'h204,       1));
    vecs.push_back(mk(0,0,0,26'h0,   0,32'h0,         0,32'h0,           1,32'h204,       32'h0,         32'h204,       0));

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Reset while a dropped request is in flight: first fetch afterwards comes from RESET_PC.
    applyStimulus(mk(0,0,0,26'h0,1,32'h300,0,32'h0,         1,32'h204,32'h0,32'h204,0), "dropA");
    rst = 1'b1;
    applyStimulus(mk(0,0,0,26'h0,0,32'h0,  1,32'h0000_0099, 1,32'h0,  32'h0,32'h0,  0), "dropRst");
    rst = 1'b0;
    applyStimulus(mk(0,0,0,26'h0,0,32'h0,  1,32'h0000_1234, 1,32'h4,  32'h0000_1234,32'h4,1), "dropPost");

    // Reset while holding a buffered word: the buffered word must not reappear.
    applyStimulus(mk(1,0,0,26'h0,0,32'h0,  1,32'h0000_0055, 0,32'h4,  32'h0000_1234,32'h4,1), "holdA");
    rst = 1'b1;
    applyStimulus(mk(1,0,0,26'h0,0,32'h0,  0,32'h0,         1,32'h0,  32'h0,32'h0,  0), "holdRst");
    rst = 1'b0;
    applyStimulus(mk(0,0,0,26'h0,0,32'h0,  1,32'h0000_0066, 1,32'h4,  32'h0000_0066,32'h4,1), "holdPost");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hold PC, IF/ID register and any fetched word.
REQ-005 flush  input  1  load bubble into IF/ID next edge.
REQ-006 jump  input  1  redirect to jump target.
REQ-007 jump_index  input  26  J-format instr_index.
REQ-008 branch_taken  input  1  redirect to branch_target.
REQ-009 branch_target  input  32  full branch target address.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  fetch address; always equals current fetch PC.
REQ-012 imem_ready  input  1  imem_rdata valid this cycle; completes request.
REQ-013 imem_rdata  input  32  fetched instruction word.
REQ-014 if_id_instr  output  32  IF/ID instruction; 32'h0000_0000 when bubble.
REQ-015 if_id_pc_plus4  output  32  IF/ID PC+4.
REQ-016 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 Op_code, Funct, Shamt, Rs, Rt  output  6/6/5/5/5  combinational slices [31:26], [5:0], [10:6], [25:21], [20:16] of if_id_instr, feeding the decode controller.

Function
REQ-018 The block SHALL implement states S_REQ, S_HOLD, S_DROP; imem_req=1 in S_REQ and S_DROP, 0 in S_HOLD.
REQ-019 imem_addr SHALL remain stable while imem_req=1 and imem_ready=0.
REQ-020 Redirect priority SHALL be branch_taken > jump; redirect SHALL override stall and flush.
REQ-021 Jump target SHALL be {if_id_pc_plus4[31:28], jump_index, 2'b00}; PC+4 SHALL wrap modulo 2^32.
REQ-022 S_REQ, ready=1, no redirect, no stall: IF/ID <= {imem_rdata, pc+4, valid=1}; pc <= pc+4; stay S_REQ.
REQ-023 S_REQ, ready=1, stall=1, no redirect: capture word in hold buffer; IF/ID held; go S_HOLD.
REQ-024 S_REQ, ready=0, no redirect: IF/ID <= bubble unless stall=1 (then held); pc held.
REQ-025 S_HOLD, stall=0, no redirect: IF/ID <= {buffer, pc+4, 1}; pc <= pc+4; go S_REQ.
REQ-026 S_HOLD, stall=1, no redirect: everything held.
REQ-027 Redirect in S_REQ with ready=1, or in S_HOLD: discard word; pc <= target; IF/ID <= bubble; go S_REQ.
REQ-028 Redirect in S_REQ with ready=0: pending_pc <= target; IF/ID <= bubble; go S_DROP.
REQ-029 S_DROP: keep old address; redirect overwrites pending_pc (latest wins); on ready=1 discard data, pc <= pending_pc (or the same-cycle redirect target), go S_REQ; IF/ID bubble throughout.
REQ-030 flush=1 without redirect SHALL load bubble into IF/ID, override stall, and leave pc/state unchanged, except that in S_REQ with ready=1 the word SHALL be captured per REQ-023.
REQ-031 Bubble SHALL be if_id_instr=0, if_id_valid=0, if_id_pc_plus4 unchanged.

Reset
REQ-032 rst=1 SHALL set pc=RESET_PC, state=S_REQ, IF/ID bubble, if_id_pc_plus4=0, hold buffer=0, pending_pc=0, and override all other inputs.
REQ-033 rst asserted in S_DROP or S_HOLD SHALL abandon the in-flight word; the first request after reset SHALL use RESET_PC.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined: add outputs perf_fetched (32, increments on each IF/ID load with valid=1) and perf_stall_cycles (32, increments each cycle stall=1 and state!=S_DROP); both wrap, cleared by rst.
REQ-035 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-036 rst 1 cycle, imem_ready=1 always, rdata 32'h2008_0005 -> cycle after: if_id_instr=32'h2008_0005, if_id_pc_plus4=4, Op_code=6'b001000, imem_addr=4.
REQ-037 ready low 3 cycles at pc=8 -> imem_addr=8 held, if_id_valid=0 for 3 cycles, then valid with pc_plus4=12.
REQ-038 stall=1 on ready beat at pc=16 for 2 cycles -> S_HOLD, imem_req=0, IF/ID unchanged; stall drop -> IF/ID gets buffered word, pc_plus4=20.
REQ-039 branch_taken=1, target 32'h0000_0100, while ready=0 -> addr unchanged until ready, data discarded, next imem_addr=32'h100, if_id_valid=0 meanwhile.
REQ-040 jump=1 and branch_taken=1 same cycle, if_id_pc_plus4=32'h1000_0008, jump_index=26'h40 -> branch_target wins; jump-only case -> pc=32'h1000_0100.
REQ-041 pc=32'hFFFF_FFFC fetch with ready=1 -> if_id_pc_plus4=0, next imem_addr=0.
